// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test controller.
//   state_e   : controller FSM states
//   SIG_W     : signature / LFSR width
//   POLY_TAPS : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   NUM_OPS   : ALU opcodes exercised per operand pair
//   OP_W      : opcode width
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned SIG_W     = 16;
  localparam logic [15:0] POLY_TAPS = 16'hB400;
  localparam int unsigned NUM_OPS   = 8;
  localparam int unsigned OP_W      = 3;

endpackage

// File: rtl/alu_bist_lfsr16_step.sv
// lfsr16_step: one combinational step of a 16-bit Fibonacci shift register
// using the package polynomial, with the new value XORed by xor_i. With
// xor_i tied to zero it is a plain LFSR step; fed with data it is a MISR step.
// Ports:
//   r_i   in  16  current register value
//   xor_i in  16  data folded into the shifted value
//   r_o   out 16  next register value
module lfsr16_step
  import alu_bist_pkg::*;
(
  input  logic [SIG_W-1:0] r_i,
  input  logic [SIG_W-1:0] xor_i,
  output logic [SIG_W-1:0] r_o
);

  logic fb;

  assign fb  = ^(r_i & POLY_TAPS);
  assign r_o = {r_i[SIG_W-2:0], fb} ^ xor_i;

endmodule

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: BIST driver/checker for the 8-op signed ALU. Issues operand
// pairs (each applied to all 8 opcodes), compacts the ALU results into a
// 16-bit MISR and compares the final signature with GOLDEN_SIG.
// Configuration macro: ALU_BIST_EXHAUSTIVE_EN -- operand pairs come from a
// 2N-bit up-counter covering all 2^(2N) pairs (NUM_VEC, LFSR_SEED ignored);
// undefined: pairs come from the 16-bit LFSR seeded with LFSR_SEED.
// Ports:
//   clk       in   1    rising-edge clock
//   rst_n     in   1    asynchronous reset, active low
//   start     in   1    starts a run from IDLE or DONE
//   alu_x     out  N    operand x to the ALU (registered)
//   alu_y     out  N    operand y to the ALU (registered)
//   alu_c     out  3    opcode to the ALU (registered)
//   alu_o     in   N+2  ALU result
//   busy      out  1    high in RUN and DRAIN
//   done      out  1    high in DONE
//   pass      out  1    signature == GOLDEN_SIG while done
//   signature out  16   current MISR value
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned NUM_VEC    = 64,
  parameter int unsigned ALU_LAT    = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N-1:0]     alu_x,
  output logic [N-1:0]     alu_y,
  output logic [OP_W-1:0]  alu_c,
  input  logic [N+1:0]     alu_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned VEC_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int unsigned DCNT_W = $clog2(ALU_LAT + 1) + 1;

  state_e state_q, state_d;

  logic [OP_W-1:0]    op_q;
  logic [N-1:0]       alu_x_q, alu_y_q;
  logic [OP_W-1:0]    alu_c_q;
  logic [ALU_LAT:0]   vld_q;
  logic [DCNT_W-1:0]  dcnt_q;
  logic [SIG_W-1:0]   misr_q, misr_d;
  logic [2*N-1:0]     pair;
  logic               last_pair;
  logic               issue, last_issue, start_run, drain_end;

`ifdef ALU_BIST_EXHAUSTIVE_EN
  logic [2*N-1:0] cnt_q;
  assign pair      = cnt_q;
  assign last_pair = &cnt_q;
`else
  logic [SIG_W-1:0] lfsr_q, lfsr_d;
  logic [VEC_W-1:0] vec_q;

  lfsr16_step u_lfsr (
    .r_i   (lfsr_q),
    .xor_i ('0),
    .r_o   (lfsr_d)
  );

  assign pair      = lfsr_q[2*N-1:0];
  assign last_pair = (vec_q == VEC_W'(NUM_VEC - 1));
`endif

  lfsr16_step u_misr (
    .r_i   (misr_q),
    .xor_i ({{(SIG_W-N-2){1'b0}}, alu_o}),
    .r_o   (misr_d)
  );

  assign issue      = (state_q == RUN);
  assign last_issue = issue && (op_q == OP_W'(NUM_OPS - 1)) && last_pair;
  assign start_run  = start && ((state_q == IDLE) || (state_q == DONE));
  assign drain_end  = (dcnt_q == DCNT_W'(ALU_LAT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_run)  state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_end)  state_d = DONE;
      DONE:    if (start_run)  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == DONE);
    pass      = (state_q == DONE) && (misr_q == GOLDEN_SIG);
    signature = misr_q;
    alu_x     = alu_x_q;
    alu_y     = alu_y_q;
    alu_c     = alu_c_q;
  end

  // Datapath: vector issue, operand source, capture pipeline, MISR.
  // The valid bit for a vector enters vld_q on its issue edge; its tap
  // vld_q[ALU_LAT] lines up with the edge on which that vector's result is
  // present on alu_o, so only real results are compacted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      alu_x_q <= '0;
      alu_y_q <= '0;
      alu_c_q <= '0;
      vld_q   <= '0;
      dcnt_q  <= '0;
      misr_q  <= '0;
`ifdef ALU_BIST_EXHAUSTIVE_EN
      cnt_q   <= '0;
`else
      lfsr_q  <= LFSR_SEED;
      vec_q   <= '0;
`endif
    end else if (start_run) begin
      op_q   <= '0;
      vld_q  <= '0;
      dcnt_q <= '0;
      misr_q <= '0;
`ifdef ALU_BIST_EXHAUSTIVE_EN
      cnt_q  <= '0;
`else
      lfsr_q <= LFSR_SEED;
      vec_q  <= '0;
`endif
    end else begin
      if (issue) begin
        alu_c_q <= op_q;
        alu_x_q <= pair[2*N-1:N];
        alu_y_q <= pair[N-1:0];
        op_q    <= op_q + OP_W'(1);
        if (op_q == OP_W'(NUM_OPS - 1)) begin
`ifdef ALU_BIST_EXHAUSTIVE_EN
          cnt_q  <= cnt_q + (2*N)'(1);
`else
          lfsr_q <= lfsr_d;
          vec_q  <= vec_q + VEC_W'(1);
`endif
        end
      end
      vld_q <= (ALU_LAT+1)'({vld_q, issue});
      if (vld_q[ALU_LAT]) begin
        misr_q <= misr_d;
      end
      if (state_q == DRAIN) begin
        dcnt_q <= dcnt_q + DCNT_W'(1);
      end else begin
        dcnt_q <= '0;
      end
    end
  end

endmodule
